// File: rtl/hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl_pkg
// Purpose  : Shared pipeline definitions for the hazard controller.
//            Holds the PCsrc encodings, the controller state type, counter
//            widths, the memory wait limit and the branch-resolve helper.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package hazard_ctrl_pkg;

  localparam int CNT_W      = 16;   // event counter width
  localparam int WAIT_W     = 8;    // memory wait counter width
  localparam int WAIT_LIMIT = 255;  // wait count at which a freeze is a timeout
  localparam int REG_W      = 5;    // register address width
  localparam int PCSRC_W    = 4;    // branch/jump class width

  // Branch/jump class of the instruction in MEM. Codes 4-15 are reserved
  // and behave as sequential.
  localparam logic [PCSRC_W-1:0] PCSRC_SEQ  = 4'd0;
  localparam logic [PCSRC_W-1:0] PCSRC_BEQ  = 4'd1;
  localparam logic [PCSRC_W-1:0] PCSRC_BNE  = 4'd2;
  localparam logic [PCSRC_W-1:0] PCSRC_JUMP = 4'd3;

  typedef enum logic [0:0] {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } hz_state_e;

  // Resolves whether the branch/jump held in MEM redirects the PC.
  function automatic logic branch_resolve(input logic [PCSRC_W-1:0] pcsrc,
                                          input logic               zero);
    logic taken;
    taken = 1'b0;
    case (pcsrc)
      PCSRC_BEQ:  taken = zero;
      PCSRC_BNE:  taken = ~zero;
      PCSRC_JUMP: taken = 1'b1;
      default:    taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl_if
// Purpose  : Bundle of pipeline status inputs and pipeline-register control
//            outputs exchanged between the datapath and the hazard controller.
// Modports : master - pipeline/datapath side (drives status, takes controls)
//            slave  - hazard controller side (takes status, drives controls)
// Revision : 1.0  initial release
// ============================================================================
interface hazard_ctrl_if;
  import hazard_ctrl_pkg::*;

  // Status from the pipeline
  logic [REG_W-1:0]   IF_ID_rs;
  logic [REG_W-1:0]   IF_ID_rt;
  logic               ID_EX_MemRead;
  logic [REG_W-1:0]   ID_EX_Dest_Reg_Addr;
  logic [PCSRC_W-1:0] EX_MEM_PCsrc;
  logic               EX_MEM_zero;
  logic               EX_MEM_MemRead;
  logic               EX_MEM_MemWrite;
  logic               mem_ready;

  // Controls back to the pipeline
  logic               PC_write;
  logic               IF_ID_write;
  logic               ID_EX_write;
  logic               EX_MEM_write;
  logic               MEM_WB_write;
  logic               IF_ID_reset;
  logic               ID_EX_reset;
  logic               EX_MEM_reset;
  logic               MEM_WB_reset;
  logic               branch_taken;
  logic               mem_timeout;
  logic [CNT_W-1:0]   stall_cycles;
  logic [CNT_W-1:0]   flush_count;

  modport master (
    output IF_ID_rs, IF_ID_rt, ID_EX_MemRead, ID_EX_Dest_Reg_Addr,
           EX_MEM_PCsrc, EX_MEM_zero, EX_MEM_MemRead, EX_MEM_MemWrite,
           mem_ready,
    input  PC_write, IF_ID_write, ID_EX_write, EX_MEM_write, MEM_WB_write,
           IF_ID_reset, ID_EX_reset, EX_MEM_reset, MEM_WB_reset,
           branch_taken, mem_timeout, stall_cycles, flush_count
  );

  modport slave (
    input  IF_ID_rs, IF_ID_rt, ID_EX_MemRead, ID_EX_Dest_Reg_Addr,
           EX_MEM_PCsrc, EX_MEM_zero, EX_MEM_MemRead, EX_MEM_MemWrite,
           mem_ready,
    output PC_write, IF_ID_write, ID_EX_write, EX_MEM_write, MEM_WB_write,
           IF_ID_reset, ID_EX_reset, EX_MEM_reset, MEM_WB_reset,
           branch_taken, mem_timeout, stall_cycles, flush_count
  );

endinterface
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter
// Purpose  : Up-counter that sticks at all-ones and can be cleared
//            synchronously. Clear has priority over increment.
// Ports    : clock  - rising-edge clock
//            reset  - asynchronous active-high reset (count -> 0)
//            clear  - synchronous clear
//            inc    - count enable
//            count  - current count
// Revision : 1.0  initial release
// ============================================================================
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] c_one = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] c_max = {WIDTH{1'b1}};

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (inc && (r_count != c_max)) begin
      r_count <= r_count + c_one;
    end
  end

  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Purpose  : Pipeline hazard controller. Freezes the pipe while data memory
//            is busy, flushes on taken branches/jumps in MEM and inserts a
//            bubble for load-use dependences. Priority: freeze > flush >
//            load-use. Tracks memory wait time and stall/flush statistics.
// Ports    : clock - rising-edge clock
//            reset - asynchronous active-high reset
//            bus   - hazard_ctrl_if.slave (pipeline status in, controls out)
// Revision : 1.0  initial release
// ============================================================================
module hazard_ctrl
  import hazard_ctrl_pkg::*;
(
  input  logic         clock,
  input  logic         reset,
  hazard_ctrl_if.slave bus
);

  localparam logic [WAIT_W-1:0] c_wait_limit = WAIT_W'(WAIT_LIMIT);

  hz_state_e         r_state;
  hz_state_e         w_state_nxt;
  logic              r_timeout;
  logic              w_mem_freeze;
  logic              w_taken;
  logic              w_load_use;
  logic              w_timeout_set;
  logic              w_wait_clr;
  logic              w_stall_inc;
  logic              w_flush_inc;
  logic [WAIT_W-1:0] w_wait_cnt;
  logic [CNT_W-1:0]  w_stall_cnt;
  logic [CNT_W-1:0]  w_flush_cnt;

  logic w_pc_write, w_if_id_write, w_id_ex_write, w_ex_mem_write, w_mem_wb_write;
  logic w_if_id_reset, w_id_ex_reset, w_ex_mem_reset, w_mem_wb_reset;
  logic w_branch_taken;

  assign w_mem_freeze = (bus.EX_MEM_MemRead | bus.EX_MEM_MemWrite) & ~bus.mem_ready;
  assign w_taken      = branch_resolve(bus.EX_MEM_PCsrc, bus.EX_MEM_zero);
  // Register 0 is hard-wired, so a load into it never creates a dependence.
  assign w_load_use   = bus.ID_EX_MemRead
                      & (bus.ID_EX_Dest_Reg_Addr != '0)
                      & ((bus.ID_EX_Dest_Reg_Addr == bus.IF_ID_rs) |
                         (bus.ID_EX_Dest_Reg_Addr == bus.IF_ID_rt));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Outputs depend only on the live freeze condition, so the release cycle
  // (MEM_WAIT with mem_ready high) naturally falls through to the normal
  // branch/load-use evaluation and a held branch resolves exactly once.
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_write     = 1'b1;
    w_if_id_write  = 1'b1;
    w_id_ex_write  = 1'b1;
    w_ex_mem_write = 1'b1;
    w_mem_wb_write = 1'b1;
    w_if_id_reset  = 1'b0;
    w_id_ex_reset  = 1'b0;
    w_ex_mem_reset = 1'b0;
    w_mem_wb_reset = 1'b0;
    w_branch_taken = 1'b0;
    w_stall_inc    = 1'b0;
    w_flush_inc    = 1'b0;

    case (r_state)
      ST_RUN:      if (w_mem_freeze)  w_state_nxt = ST_MEM_WAIT;
      ST_MEM_WAIT: if (!w_mem_freeze) w_state_nxt = ST_RUN;
      default:     w_state_nxt = ST_RUN;
    endcase

    if (reset) begin
      w_pc_write     = 1'b0;
      w_if_id_write  = 1'b0;
      w_id_ex_write  = 1'b0;
      w_ex_mem_write = 1'b0;
      w_mem_wb_write = 1'b0;
      w_if_id_reset  = 1'b1;
      w_id_ex_reset  = 1'b1;
      w_ex_mem_reset = 1'b1;
      w_mem_wb_reset = 1'b1;
    end else if (w_mem_freeze) begin
      // Hold everything up to MEM; feed a bubble into WB.
      w_pc_write     = 1'b0;
      w_if_id_write  = 1'b0;
      w_id_ex_write  = 1'b0;
      w_ex_mem_write = 1'b0;
      w_mem_wb_reset = 1'b1;
      w_stall_inc    = 1'b1;
    end else if (w_taken) begin
      w_branch_taken = 1'b1;
      w_if_id_reset  = 1'b1;
      w_id_ex_reset  = 1'b1;
      w_ex_mem_reset = 1'b1;
      w_flush_inc    = 1'b1;
    end else if (w_load_use) begin
      w_pc_write     = 1'b0;
      w_if_id_write  = 1'b0;
      w_id_ex_reset  = 1'b1;
      w_stall_inc    = 1'b1;
    end
  end

  // Wait count restarts whenever the controller leaves MEM_WAIT.
  assign w_wait_clr    = (r_state == ST_MEM_WAIT) & ~w_mem_freeze;
  assign w_timeout_set = w_mem_freeze & (w_wait_cnt == c_wait_limit);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_timeout <= 1'b0;
    end else if (w_timeout_set) begin
      r_timeout <= 1'b1;
    end
  end

  sat_counter #(.WIDTH(WAIT_W)) u_wait_cnt (
    .clock (clock),
    .reset (reset),
    .clear (w_wait_clr),
    .inc   (w_mem_freeze),
    .count (w_wait_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clock (clock),
    .reset (reset),
    .clear (1'b0),
    .inc   (w_stall_inc),
    .count (w_stall_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clock (clock),
    .reset (reset),
    .clear (1'b0),
    .inc   (w_flush_inc),
    .count (w_flush_cnt)
  );

  assign bus.PC_write     = w_pc_write;
  assign bus.IF_ID_write  = w_if_id_write;
  assign bus.ID_EX_write  = w_id_ex_write;
  assign bus.EX_MEM_write = w_ex_mem_write;
  assign bus.MEM_WB_write = w_mem_wb_write;
  assign bus.IF_ID_reset  = w_if_id_reset;
  assign bus.ID_EX_reset  = w_id_ex_reset;
  assign bus.EX_MEM_reset = w_ex_mem_reset;
  assign bus.MEM_WB_reset = w_mem_wb_reset;
  assign bus.branch_taken = w_branch_taken;
  // The flag is visible in the very freeze cycle that trips the limit.
  assign bus.mem_timeout  = r_timeout | w_timeout_set;
  assign bus.stall_cycles = w_stall_cnt;
  assign bus.flush_count  = w_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_ctrl
// Purpose  : Self-checking bench for hazard_ctrl. Each cycle's expected
//            controls/counters are predicted from the stimulus, queued, and
//            compared against the DUT on the falling edge.
// Revision : 1.0  initial release
// ============================================================================
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  logic clock = 1'b0;
  logic reset;

  hazard_ctrl_if bus ();

  hazard_ctrl dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       id_mr;
    logic [4:0] dest;
    logic [3:0] pcsrc;
    logic       zero;
    logic       ex_rd;
    logic       ex_wr;
    logic       ready;
  } stim_t;

  // wr = {PC, IF_ID, ID_EX, EX_MEM, MEM_WB}; rst = {IF_ID, ID_EX, EX_MEM, MEM_WB}
  typedef struct packed {
    logic [4:0]  wr;
    logic [3:0]  rst;
    logic        bt;
    logic        to;
    logic [15:0] stall;
    logic [15:0] flush;
    logic        st;
  } exp_t;

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;
  string       phase  = "init";
  exp_t        sb[$];

  // Reference model state
  int m_wait  = 0;
  int m_stall = 0;
  int m_flush = 0;
  bit m_to    = 0;
  bit m_state = 0;
  bit m_freeze, m_lu, m_bt, m_to_now;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s/%s: got %0h, expected %0h", phase, tag, obs, exp);
    end
  endtask

  function automatic stim_t mk(input int rs, input int rt, input bit id_mr, input int dest,
                               input int pcsrc, input bit zero, input bit ex_rd,
                               input bit ex_wr, input bit ready);
    stim_t s;
    s.rs = 5'(rs); s.rt = 5'(rt); s.id_mr = id_mr; s.dest = 5'(dest);
    s.pcsrc = 4'(pcsrc); s.zero = zero; s.ex_rd = ex_rd; s.ex_wr = ex_wr; s.ready = ready;
    return s;
  endfunction

  function automatic exp_t predict(input stim_t s, input bit in_reset);
    exp_t e;
    bit   freeze, taken, lu;
    freeze = (s.ex_rd || s.ex_wr) && !s.ready;
    taken  = (s.pcsrc == 4'd1) ? s.zero : (s.pcsrc == 4'd2) ? !s.zero : (s.pcsrc == 4'd3);
    lu     = s.id_mr && (s.dest != 5'd0) && (s.dest == s.rs || s.dest == s.rt);
    e.wr = 5'b11111; e.rst = 4'b0000; e.bt = 1'b0;
    m_freeze = 0; m_lu = 0; m_bt = 0;
    if (in_reset) begin
      e.wr = 5'b00000; e.rst = 4'b1111;
    end else if (freeze) begin
      e.wr = 5'b00001; e.rst = 4'b0001; m_freeze = 1;
    end else if (taken) begin
      e.bt = 1'b1; e.rst = 4'b1110; m_bt = 1;
    end else if (lu) begin
      e.wr = 5'b00111; e.rst = 4'b0100; m_lu = 1;
    end
    m_to_now = m_to || (m_freeze && m_wait == 255);
    e.to    = m_to_now;
    e.stall = 16'(m_stall);
    e.flush = 16'(m_flush);
    e.st    = m_state;
    return e;
  endfunction

  task automatic advance();
    m_wait  = m_freeze ? ((m_wait < 255) ? m_wait + 1 : 255) : 0;
    m_to    = m_to_now;
    m_state = m_freeze;
    if ((m_freeze || m_lu) && m_stall < 65535) m_stall++;
    if (m_bt && m_flush < 65535) m_flush++;
  endtask

  task automatic drive(input stim_t s);
    bus.IF_ID_rs            = s.rs;
    bus.IF_ID_rt            = s.rt;
    bus.ID_EX_MemRead       = s.id_mr;
    bus.ID_EX_Dest_Reg_Addr = s.dest;
    bus.EX_MEM_PCsrc        = s.pcsrc;
    bus.EX_MEM_zero         = s.zero;
    bus.EX_MEM_MemRead      = s.ex_rd;
    bus.EX_MEM_MemWrite     = s.ex_wr;
    bus.mem_ready           = s.ready;
  endtask

  task automatic compare_head();
    exp_t e;
    if (sb.size() == 0) begin
      check_val("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check_val("PC_write",     32'(bus.PC_write),     32'(e.wr[4]));
      check_val("IF_ID_write",  32'(bus.IF_ID_write),  32'(e.wr[3]));
      check_val("ID_EX_write",  32'(bus.ID_EX_write),  32'(e.wr[2]));
      check_val("EX_MEM_write", 32'(bus.EX_MEM_write), 32'(e.wr[1]));
      check_val("MEM_WB_write", 32'(bus.MEM_WB_write), 32'(e.wr[0]));
      check_val("IF_ID_reset",  32'(bus.IF_ID_reset),  32'(e.rst[3]));
      check_val("ID_EX_reset",  32'(bus.ID_EX_reset),  32'(e.rst[2]));
      check_val("EX_MEM_reset", 32'(bus.EX_MEM_reset), 32'(e.rst[1]));
      check_val("MEM_WB_reset", 32'(bus.MEM_WB_reset), 32'(e.rst[0]));
      check_val("branch_taken", 32'(bus.branch_taken), 32'(e.bt));
      check_val("mem_timeout",  32'(bus.mem_timeout),  32'(e.to));
      check_val("stall_cycles", 32'(bus.stall_cycles), 32'(e.stall));
      check_val("flush_count",  32'(bus.flush_count),  32'(e.flush));
      check_val("state",        32'(dut.r_state),      32'(e.st));
    end
  endtask

  // One clock cycle: inputs change just after the rising edge, outputs are
  // checked on the falling edge, model state advances after the next edge.
  task automatic step(input stim_t s);
    drive(s);
    sb.push_back(predict(s, 1'b0));
    @(negedge clock);
    compare_head();
    @(posedge clock);
    #1;
    advance();
  endtask

  // Asserts reset between clock edges and checks the effect before any edge.
  task automatic reset_check(input stim_t s);
    stim_t idle;
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 1);
    drive(s);
    #2;
    reset = 1'b1;
    m_wait = 0; m_stall = 0; m_flush = 0; m_to = 0; m_state = 0;
    #1;
    sb.push_back(predict(s, 1'b1));
    compare_head();
    @(posedge clock);
    #1;
    sb.push_back(predict(s, 1'b1));
    compare_head();
    drive(idle);
    #2;
    reset = 1'b0;
    @(posedge clock);
    #1;
  endtask

  stim_t idle, s;

  initial begin
    reset = 1'b1;
    idle  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1);
    drive(idle);

    phase = "reset";     reset_check(idle);
    phase = "idle";      repeat (2) step(idle);

    phase = "load_use_rs"; step(mk(5, 3, 1, 5, 0, 0, 0, 0, 1)); step(idle);
    phase = "load_use_rt"; step(mk(2, 7, 1, 7, 0, 0, 0, 0, 1)); step(idle);
    phase = "load_x0";     step(mk(0, 0, 1, 0, 0, 0, 0, 0, 1));
    phase = "no_match";    step(mk(1, 2, 1, 3, 0, 0, 0, 0, 1));
    phase = "no_memread";  step(mk(5, 5, 0, 5, 0, 0, 0, 0, 1));

    phase = "beq_taken";   step(mk(0, 0, 0, 0, 1, 1, 0, 0, 1)); step(idle);
    phase = "bne_z1";      step(mk(0, 0, 0, 0, 2, 1, 0, 0, 1));
    phase = "bne_z0";      step(mk(0, 0, 0, 0, 2, 0, 0, 0, 1));
    phase = "jump";        step(mk(0, 0, 0, 0, 3, 0, 0, 0, 1));
    phase = "beq_z0";      step(mk(0, 0, 0, 0, 1, 0, 0, 0, 1));
    for (int k = 4; k < 16; k++) begin
      phase = "reserved";  step(mk(0, 0, 0, 0, k, k % 2, 0, 0, 1));
    end

    phase = "freeze3";
    repeat (3) step(mk(0, 0, 0, 0, 0, 0, 1, 0, 0));
    step(mk(0, 0, 0, 0, 0, 0, 1, 0, 1));
    step(idle);

    phase = "combined";
    repeat (2) step(mk(5, 0, 1, 5, 1, 1, 1, 0, 0));
    step(mk(5, 0, 1, 5, 1, 1, 1, 0, 1));
    step(idle);

    phase = "withdraw";
    repeat (2) step(mk(0, 0, 0, 0, 0, 0, 0, 1, 0));
    step(idle);
    step(idle);

    phase = "timeout";
    repeat (300) step(mk(0, 0, 0, 0, 0, 0, 1, 0, 0));
    phase = "reset_mid_wait";
    reset_check(mk(0, 0, 0, 0, 0, 0, 1, 0, 0));
    step(idle);

    phase = "stall_sat";
    repeat (65540) step(mk(0, 0, 0, 0, 0, 0, 0, 1, 0));
    step(mk(3, 0, 1, 3, 0, 0, 0, 0, 1));
    step(mk(0, 0, 0, 0, 3, 0, 0, 0, 1));
    step(idle);

    phase = "final_reset";
    reset_check(idle);
    step(idle);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
